// File: rtl/acq_controller_if.sv
// Acquisition datapath bundle: ADC sample stream in, capture-RAM write port
// and the frame hand-off to the display path.
interface acq_controller_if #(
    parameter int DATA_W = 12,
    parameter int ADDR_W = 8
);
    logic [DATA_W-1:0] adc_data;
    logic              adc_valid;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic              frame_ready;
    logic              frame_ack;

    modport master (
        input  adc_data, adc_valid, frame_ack,
        output wr_en, wr_addr, wr_data, frame_ready
    );

    modport slave (
        output adc_data, adc_valid, frame_ack,
        input  wr_en, wr_addr, wr_data, frame_ready
    );
endinterface

// File: rtl/acq_controller.sv
// Scope acquisition sequencer: decimator, hysteresis edge trigger with
// auto/normal/single modes, one-frame capture into RAM and display hand-off.
module acq_controller #(
    parameter int DATA_W       = 12,
    parameter int DEPTH        = 256,
    parameter int ADDR_W       = 8,
    parameter int AUTO_TIMEOUT = 4096
) (
    input  logic              clk,
    input  logic              rst,
    acq_controller_if.master  bus,
    input  logic [DATA_W-1:0] level,
    input  logic [DATA_W-1:0] hyst,
    input  logic              slope,
    input  logic [1:0]        mode,
    input  logic              arm,
    input  logic [11:0]       decim,
    output logic              auto_trig,
    output logic              busy,
    output logic [2:0]        state_o
);

    localparam int TCNT_W = $clog2(AUTO_TIMEOUT) + 1;
    localparam logic [DATA_W:0] SAMPLE_MAX = {1'b0, {DATA_W{1'b1}}};

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_PRE     = 3'd1,
        S_ARMED   = 3'd2,
        S_CAPTURE = 3'd3,
        S_DONE    = 3'd4
    } state_t;

    function automatic logic [DATA_W:0] sat_lo(input logic [DATA_W-1:0] lvl,
                                               input logic [DATA_W-1:0] h);
        return (lvl >= h) ? {1'b0, lvl - h} : '0;
    endfunction

    function automatic logic [DATA_W:0] sat_hi(input logic [DATA_W-1:0] lvl,
                                               input logic [DATA_W-1:0] h);
        logic [DATA_W:0] sum;
        sum = {1'b0, lvl} + {1'b0, h};
        return (sum > SAMPLE_MAX) ? SAMPLE_MAX : sum;
    endfunction

    state_t            state, state_nx;
    logic [11:0]       dcnt, dcnt_nx;
    logic [TCNT_W-1:0] tcnt, tcnt_nx;
    logic [ADDR_W-1:0] wcnt, wcnt_nx;
    logic              wr_en_q, wr_en_nx;
    logic [ADDR_W-1:0] wr_addr_q, wr_addr_nx;
    logic [DATA_W-1:0] wr_data_q, wr_data_nx;
    logic              frame_ready_q, frame_ready_nx;
    logic              auto_trig_q, auto_trig_nx;
    logic              busy_q, busy_nx;

    logic              tick;
    logic              fire;
    logic [DATA_W:0]   thr_lo, thr_hi, sample_x;
    logic              edge_hit, band_exit;

    assign thr_lo    = sat_lo(level, hyst);
    assign thr_hi    = sat_hi(level, hyst);
    assign sample_x  = {1'b0, bus.adc_data};
    assign edge_hit  = slope ? (bus.adc_data <= level) : (bus.adc_data >= level);
    assign band_exit = slope ? (sample_x > thr_hi) : (sample_x < thr_lo);
    // >= rather than == so a lowered decim mid-run ticks at once instead of wrapping
    assign tick      = bus.adc_valid && (dcnt >= decim);

    always_comb begin
        state_nx     = state;
        dcnt_nx      = dcnt;
        tcnt_nx      = tcnt;
        wcnt_nx      = wcnt;
        wr_en_nx     = 1'b0;
        wr_addr_nx   = wr_addr_q;
        wr_data_nx   = wr_data_q;
        auto_trig_nx = auto_trig_q;
        fire         = 1'b0;

        if (state == S_IDLE || state == S_DONE) begin
            dcnt_nx = '0;
        end else if (bus.adc_valid) begin
            dcnt_nx = tick ? '0 : dcnt + 12'd1;
        end

        case (state)
            S_IDLE: begin
                if (mode == 2'b00 || mode == 2'b01 || (mode == 2'b10 && arm)) begin
                    state_nx     = S_PRE;
                    tcnt_nx      = '0;
                    auto_trig_nx = 1'b0;
                end
            end
            S_PRE, S_ARMED: begin
                if (mode == 2'b11) begin
                    state_nx = S_IDLE;
                end else if (tick) begin
                    tcnt_nx = tcnt + 1'b1;
                    if (state == S_ARMED && edge_hit) begin
                        fire = 1'b1;
                    end else if (mode == 2'b00 && tcnt == TCNT_W'(AUTO_TIMEOUT - 1)) begin
                        fire         = 1'b1;
                        auto_trig_nx = 1'b1;
                    end else if (state == S_PRE && band_exit) begin
                        state_nx = S_ARMED;
                    end
                end
            end
            S_CAPTURE: begin
                if (tick) begin
                    wr_en_nx   = 1'b1;
                    wr_addr_nx = wcnt;
                    wr_data_nx = bus.adc_data;
                    wcnt_nx    = wcnt + 1'b1;
                    if (wcnt == ADDR_W'(DEPTH - 1)) begin
                        state_nx = S_DONE;
                    end
                end
            end
            S_DONE: begin
                if (frame_ready_q && bus.frame_ack) begin
                    state_nx = S_IDLE;
                end
            end
            default: state_nx = S_IDLE;
        endcase

        // The triggering sample itself lands at address 0
        if (fire) begin
            wr_en_nx   = 1'b1;
            wr_addr_nx = '0;
            wr_data_nx = bus.adc_data;
            wcnt_nx    = ADDR_W'(1);
            state_nx   = S_CAPTURE;
        end

        frame_ready_nx = (state == S_DONE) && !(frame_ready_q && bus.frame_ack);
        busy_nx        = (state_nx == S_PRE) || (state_nx == S_ARMED) || (state_nx == S_CAPTURE);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state         <= S_IDLE;
            dcnt          <= '0;
            tcnt          <= '0;
            wcnt          <= '0;
            wr_en_q       <= 1'b0;
            wr_addr_q     <= '0;
            wr_data_q     <= '0;
            frame_ready_q <= 1'b0;
            auto_trig_q   <= 1'b0;
            busy_q        <= 1'b0;
        end else begin
            state         <= state_nx;
            dcnt          <= dcnt_nx;
            tcnt          <= tcnt_nx;
            wcnt          <= wcnt_nx;
            wr_en_q       <= wr_en_nx;
            wr_addr_q     <= wr_addr_nx;
            wr_data_q     <= wr_data_nx;
            frame_ready_q <= frame_ready_nx;
            auto_trig_q   <= auto_trig_nx;
            busy_q        <= busy_nx;
        end
    end

    assign bus.wr_en       = wr_en_q;
    assign bus.wr_addr     = wr_addr_q;
    assign bus.wr_data     = wr_data_q;
    assign bus.frame_ready = frame_ready_q;
    assign auto_trig       = auto_trig_q;
    assign busy            = busy_q;
    assign state_o         = state;

endmodule

// File: tb/tb_acq_controller.sv
// Directed bench for acq_controller: a sample-level model of the sequencer
// is checked every cycle, plus literal expectations for each scenario.
module tb_acq_controller;

    localparam int TB_AUTO  = 16;
    localparam int TB_DEPTH = 256;

    logic        clk;
    logic        rst;
    logic [11:0] level, hyst, decim;
    logic        slope, arm;
    logic [1:0]  mode;
    logic        auto_trig, busy;
    logic [2:0]  state_o;

    acq_controller_if #(.DATA_W(12), .ADDR_W(8)) bus ();

    acq_controller #(
        .DATA_W(12), .DEPTH(TB_DEPTH), .ADDR_W(8), .AUTO_TIMEOUT(TB_AUTO)
    ) dut (
        .clk(clk), .rst(rst), .bus(bus.master),
        .level(level), .hyst(hyst), .slope(slope), .mode(mode), .arm(arm),
        .decim(decim), .auto_trig(auto_trig), .busy(busy), .state_o(state_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    // model state: phase uses the status encoding (0 idle .. 4 done)
    int m_phase, m_div, m_ticks, m_pos;
    int e_wr_en, e_addr, e_data, e_ready, e_auto, e_busy, e_state;

    // observation bookkeeping
    int cyc = 0, sval = 0;
    int nwr, first_data, second_data, last_data, last_addr, last_wr_cyc;
    bit ready_seen;
    int ready_cyc;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_phase = 0; m_div = 0; m_ticks = 0; m_pos = 0;
        e_wr_en = 0; e_addr = 0; e_data = 0; e_ready = 0;
        e_auto = 0; e_busy = 0; e_state = 0;
    endtask

    // One clock of the sequencer, as seen from the sample stream
    task automatic model_step();
        int lo, hi, d, nxt;
        bit keep, go, acked, edge_ok, left_band;
        if (!rst) begin
            model_reset();
            return;
        end
        lo = int'(level) - int'(hyst);
        if (lo < 0) lo = 0;
        hi = int'(level) + int'(hyst);
        if (hi > 4095) hi = 4095;
        d         = int'(bus.adc_data);
        edge_ok   = slope ? (d <= int'(level)) : (d >= int'(level));
        left_band = slope ? (d > hi) : (d < lo);
        keep      = 1'b0;
        go        = 1'b0;
        acked     = (e_ready != 0) && bus.frame_ack;
        nxt       = m_phase;
        e_wr_en   = 0;

        if (m_phase == 0 || m_phase == 4) m_div = 0;
        else if (bus.adc_valid) begin
            if (m_div >= int'(decim)) begin keep = 1'b1; m_div = 0; end
            else m_div = m_div + 1;
        end

        if (m_phase == 0) begin
            if (mode != 2'b11 && (mode != 2'b10 || arm)) begin
                nxt = 1; m_ticks = 0; e_auto = 0;
            end
        end else if (m_phase == 1 || m_phase == 2) begin
            if (mode == 2'b11) nxt = 0;
            else if (keep) begin
                m_ticks = m_ticks + 1;
                if (m_phase == 2 && edge_ok) go = 1'b1;
                else if (mode == 2'b00 && m_ticks == TB_AUTO) begin go = 1'b1; e_auto = 1; end
                else if (m_phase == 1 && left_band) nxt = 2;
            end
        end else if (m_phase == 3) begin
            if (keep) begin
                e_wr_en = 1; e_addr = m_pos; e_data = d; m_pos = m_pos + 1;
                if (m_pos == TB_DEPTH) nxt = 4;
            end
        end else if (m_phase == 4) begin
            if (acked) nxt = 0;
        end

        if (go) begin
            e_wr_en = 1; e_addr = 0; e_data = d; m_pos = 1; nxt = 3;
        end
        e_ready = (m_phase == 4 && !acked) ? 1 : 0;
        m_phase = nxt;
        e_state = nxt;
        e_busy  = (nxt >= 1 && nxt <= 3) ? 1 : 0;
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            check("wr_en", int'(bus.wr_en), e_wr_en);
            if (e_wr_en != 0) begin
                check("wr_addr", int'(bus.wr_addr), e_addr);
                check("wr_data", int'(bus.wr_data), e_data);
            end
            check("frame_ready", int'(bus.frame_ready), e_ready);
            check("auto_trig", int'(auto_trig), e_auto);
            check("busy", int'(busy), e_busy);
            check("state_o", int'(state_o), e_state);
        end
    end

    task automatic tick_cyc(input bit v, input int d);
        bus.adc_valid = v;
        bus.adc_data  = 12'(d);
        @(posedge clk);
        model_step();
        #2;
        cyc++;
        if (bus.wr_en) begin
            nwr++;
            if (nwr == 1) first_data = int'(bus.wr_data);
            if (nwr == 2) second_data = int'(bus.wr_data);
            last_data   = int'(bus.wr_data);
            last_addr   = int'(bus.wr_addr);
            last_wr_cyc = cyc;
        end
        if (bus.frame_ready && !ready_seen) begin
            ready_seen = 1'b1;
            ready_cyc  = cyc;
        end
    endtask

    task automatic feed(input int step, input bit gap);
        bit v;
        v = gap ? (cyc % 3 != 2) : 1'b1;
        tick_cyc(v, sval);
        if (v) sval += step;
    endtask

    task automatic new_frame();
        nwr = 0; ready_seen = 1'b0; ready_cyc = 0;
        first_data = -1; second_data = -1; last_data = -1; last_addr = -1; last_wr_cyc = 0;
    endtask

    task automatic feed_until_ready(input string name, input int bound, input int step, input bit gap);
        int n;
        n = 0;
        while (!ready_seen && n < bound) begin feed(step, gap); n++; end
        check(name, int'(ready_seen), 1);
    endtask

    task automatic ack_pulse();
        bus.frame_ack = 1'b1;
        tick_cyc(1'b1, sval);
        bus.frame_ack = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        rst = 1'b1; mode = 2'b11; slope = 1'b0; arm = 1'b0;
        level = 12'd2048; hyst = 12'd50; decim = 12'd0;
        bus.adc_valid = 1'b0; bus.adc_data = '0; bus.frame_ack = 1'b0;
        model_reset();
        new_frame();
        #1 rst = 1'b0;
        #1;
        chk_en = 1'b1;
        check("reset_state", int'(state_o), 0);
        check("reset_wr_en", int'(bus.wr_en), 0);
        check("reset_busy", int'(busy), 0);
        check("reset_ready", int'(bus.frame_ready), 0);
        repeat (3) tick_cyc(1'b0, 0);
        rst = 1'b1;
        tick_cyc(1'b0, 0);

        // 1: normal mode, rising ramp, full frame
        mode = 2'b01; sval = 1900; new_frame();
        feed_until_ready("t1_frame_done", 700, 1, 1'b0);
        check("t1_nwr", nwr, 256);
        check("t1_first", first_data, 2048);
        check("t1_last", last_data, 2303);
        check("t1_last_addr", last_addr, 255);
        check("t1_ready_lag", ready_cyc - last_wr_cyc, 1);
        check("t1_auto", int'(auto_trig), 0);

        // 2: wobble inside the band, then clamped thresholds
        ack_pulse();
        new_frame();
        for (int i = 0; i < 40; i++) tick_cyc(1'b1, (i % 2) ? 2060 : 2040);
        check("t2_nwr", nwr, 0);
        check("t2_state", int'(state_o), 1);
        level = 12'd30;
        for (int i = 0; i < 10; i++) tick_cyc(1'b1, 0);
        check("t2_lo_clamp", int'(state_o), 1);
        slope = 1'b1; level = 12'd4080;
        for (int i = 0; i < 10; i++) tick_cyc(1'b1, 4095);
        check("t2_hi_clamp", int'(state_o), 1);
        check("t2_nwr_end", nwr, 0);

        // 3: stop, then auto mode forced trigger on constant input
        mode = 2'b11;
        tick_cyc(1'b1, 100);
        check("t3_stop", int'(state_o), 0);
        slope = 1'b0; level = 12'd2048; hyst = 12'd50; decim = 12'd0;
        mode = 2'b00; sval = 100; new_frame();
        k = 0;
        do begin tick_cyc(1'b1, 100); k++; end while (!bus.wr_en && k < 100);
        check("t3_force_cycle", k, 17);
        check("t3_auto_set", int'(auto_trig), 1);
        feed_until_ready("t3_frame_done", 400, 0, 1'b0);
        check("t3_nwr", nwr, 256);
        check("t3_last", last_data, 100);
        check("t3_auto_done", int'(auto_trig), 1);
        mode = 2'b11;
        ack_pulse();
        tick_cyc(1'b0, 0);
        check("t3_idle", int'(state_o), 0);

        // 4: decimation by 4 with gaps, then decim 9 -> 2 mid-capture
        decim = 12'd3; mode = 2'b01; sval = 1900; new_frame();
        k = 0;
        while (nwr < 2 && k < 2000) begin feed(1, 1'b1); k++; end
        check("t4_two_writes", nwr, 2);
        check("t4_stride", second_data - first_data, 4);
        decim = 12'd9;
        for (int i = 0; i < 7; i++) begin
            tick_cyc(1'b1, sval); sval++;
            tick_cyc(1'b0, 0);
        end
        check("t4_hold_at_dcnt7", nwr, 2);
        decim = 12'd2;
        tick_cyc(1'b1, sval); sval++;
        check("t4_immediate_tick", int'(bus.wr_en), 1);
        check("t4_nwr3", nwr, 3);
        feed_until_ready("t4_frame_done", 3000, 1, 1'b1);
        check("t4_nwr", nwr, 256);

        // 5: single mode waits for arm, captures once, does not re-arm
        mode = 2'b10; decim = 12'd0;
        ack_pulse();
        for (int i = 0; i < 20; i++) tick_cyc(1'b1, 1900);
        check("t5_no_arm", int'(state_o), 0);
        arm = 1'b1;
        tick_cyc(1'b1, 1900);
        arm = 1'b0;
        check("t5_armed", int'(state_o), 1);
        sval = 1900; new_frame();
        feed_until_ready("t5_frame_done", 700, 1, 1'b0);
        check("t5_nwr", nwr, 256);
        check("t5_first", first_data, 2048);
        ack_pulse();
        for (int i = 0; i < 20; i++) tick_cyc(1'b1, 1900);
        check("t5_no_rearm", int'(state_o), 0);
        check("t5_no_more_writes", nwr, 256);

        // 6: ack ignored in ARMED; async reset at wcnt=100
        mode = 2'b01; sval = 1900; new_frame();
        k = 0;
        while (state_o != 3'd2 && k < 50) begin feed(1, 1'b0); k++; end
        check("t6_reach_armed", int'(state_o), 2);
        ack_pulse();
        check("t6_ack_ignored", int'(state_o), 2);
        k = 0;
        while (nwr < 100 && k < 400) begin feed(1, 1'b0); k++; end
        check("t6_wcnt100", nwr, 100);
        rst = 1'b0;
        #1;
        model_reset();
        check("t6_rst_wr_en", int'(bus.wr_en), 0);
        check("t6_rst_addr", int'(bus.wr_addr), 0);
        check("t6_rst_data", int'(bus.wr_data), 0);
        check("t6_rst_ready", int'(bus.frame_ready), 0);
        check("t6_rst_busy", int'(busy), 0);
        check("t6_rst_state", int'(state_o), 0);
        check("t6_rst_auto", int'(auto_trig), 0);
        #1;
        repeat (3) feed(1, 1'b0);
        check("t6_no_writes", nwr, 100);
        mode = 2'b11;
        rst = 1'b1;
        repeat (3) feed(1, 1'b0);
        check("t6_idle_after", int'(state_o), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
